// File: rtl/instr_fetch_if.sv
// Fetch-stage bus for the X9 core: control inputs, ROM data, branch-table
// write port and the decoded fields handed to the control decoder.
interface instr_fetch_if #(
    parameter int PC_W    = 10,
    parameter int INSTR_W = 9,
    parameter int OPC_W   = 5,
    parameter int IDX_W   = 4
) ();
    logic               Start;
    logic               Stall;
    logic               Branch;
    logic               Taken;
    logic [INSTR_W-1:0] InstrIn;
    logic               LutWe;
    logic [IDX_W-1:0]   LutAddr;
    logic [PC_W-1:0]    LutData;
    logic [PC_W-1:0]    PC;
    logic [OPC_W-1:0]   Opcode;
    logic [IDX_W-1:0]   Operand;
    logic               InstValid;
    logic               Done;

    modport master (
        output Start, Stall, Branch, Taken, InstrIn, LutWe, LutAddr, LutData,
        input  PC, Opcode, Operand, InstValid, Done
    );

    modport slave (
        input  Start, Stall, Branch, Taken, InstrIn, LutWe, LutAddr, LutData,
        output PC, Opcode, Operand, InstValid, Done
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage for the X9 core: owns the program counter, latches
// the ROM word into the instruction register, redirects taken branches through
// a writable 16-entry target table and stops on the halt opcode.
module instr_fetch #(
    parameter int              PC_W     = 10,
    parameter int              INSTR_W  = 9,
    parameter int              OPC_W    = 5,
    parameter int              IDX_W    = 4,
    parameter logic [OPC_W-1:0] HALT_OPC = 5'b11111
) (
    input logic         Clk,
    input logic         Reset,
    instr_fetch_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} fetchStateT;

    fetchStateT         state, stateNext;
    logic [PC_W-1:0]    pc, pcNext;
    logic [INSTR_W-1:0] ir, irNext;
    logic               instValid, instValidNext;
    logic               done, doneNext;
    logic [PC_W-1:0]    branchTable [0:(1<<IDX_W)-1];

    logic [OPC_W-1:0]   opcode;
    logic [IDX_W-1:0]   operand;
    logic               isHalt;
    logic               isRedirect;

    assign opcode     = ir[INSTR_W-1 -: OPC_W];
    assign operand    = ir[IDX_W-1:0];
    assign isHalt     = instValid && (opcode == HALT_OPC);
    assign isRedirect = instValid && bus.Branch && bus.Taken;

    assign bus.PC        = pc;
    assign bus.Opcode    = opcode;
    assign bus.Operand   = operand;
    assign bus.InstValid = instValid;
    assign bus.Done      = done;

    // Next-state and datapath selection: halt beats redirect beats normal fetch,
    // and a stall simply holds everything (including a pending redirect).
    always_comb begin
        stateNext     = state;
        pcNext        = pc;
        irNext        = ir;
        instValidNext = instValid;
        doneNext      = done;
        case (state)
            IDLE: begin
                if (bus.Start) begin
                    stateNext     = RUN;
                    pcNext        = '0;
                    irNext        = '0;
                    instValidNext = 1'b0;
                end
            end
            RUN: begin
                if (!bus.Stall) begin
                    if (isHalt) begin
                        stateNext     = DONE;
                        doneNext      = 1'b1;
                        instValidNext = 1'b0;
                    end else if (isRedirect) begin
                        pcNext        = branchTable[operand];
                        irNext        = '0;
                        instValidNext = 1'b0;
                    end else begin
                        irNext        = bus.InstrIn;
                        instValidNext = 1'b1;
                        pcNext        = pc + 1'b1;
                    end
                end
            end
            DONE: begin
                if (bus.Start) begin
                    stateNext     = RUN;
                    pcNext        = '0;
                    irNext        = '0;
                    instValidNext = 1'b0;
                    doneNext      = 1'b0;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // State and fetch registers; reset returns to an empty, idle stage.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            pc        <= '0;
            ir        <= '0;
            instValid <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= stateNext;
            pc        <= pcNext;
            ir        <= irNext;
            instValid <= instValidNext;
            done      <= doneNext;
        end
    end

    // Branch-target table: writable in any state; a same-edge redirect reads the old entry.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < (1 << IDX_W); i++) begin
                branchTable[i] <= '0;
            end
        end else if (bus.LutWe) begin
            branchTable[bus.LutAddr] <= bus.LutData;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: directed programs push the instructions
// expected at the decoder into a queue, a negedge monitor pops and compares
// every instruction the stage hands over, and direct checks cover bubbles,
// stalls, halt and reset.
module tb_instr_fetch;

    localparam logic [4:0] ADD  = 5'b00000;
    localparam logic [4:0] SUB  = 5'b00001;
    localparam logic [4:0] XOR  = 5'b01000;
    localparam logic [4:0] BEQ  = 5'b10000;
    localparam logic [4:0] HALT = 5'b11111;

    typedef struct packed {
        logic [4:0] opc;
        logic [3:0] opr;
        logic [9:0] pc;
    } expT;

    logic       Clk;
    logic       Reset;
    logic       takenSel;
    logic       forceBranch;
    logic [8:0] rom [0:1023];
    expT        expQ [$];
    int         errors;
    int         checks;

    instr_fetch_if #(.PC_W(10), .INSTR_W(9), .OPC_W(5), .IDX_W(4)) bus ();

    instr_fetch #(.PC_W(10), .INSTR_W(9), .OPC_W(5), .IDX_W(4)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    // ROM and branch control behave like the real neighbours: combinational on PC / Opcode
    assign bus.InstrIn = rom[bus.PC];
    assign bus.Branch  = (bus.Opcode == BEQ) || forceBranch;
    assign bus.Taken   = takenSel;

    always #5 Clk = ~Clk;

    // Monitor: every instruction consumed by the decoder must match the queue head
    always @(negedge Clk) begin
        if (!Reset && bus.InstValid && !bus.Stall) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_instr: got opc=%b opr=%0d pc=%0d, queue empty",
                         bus.Opcode, bus.Operand, bus.PC);
            end else begin
                expT e;
                e = expQ.pop_front();
                if ({bus.Opcode, bus.Operand, bus.PC} !== e) begin
                    errors++;
                    $display("[TB] FAIL instr_stream: got opc=%b opr=%0d pc=%0d, expected opc=%b opr=%0d pc=%0d",
                             bus.Opcode, bus.Operand, bus.PC, e.opc, e.opr, e.pc);
                end
            end
        end
    end

    // Watchdog so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [8:0] mk(input logic [4:0] opc, input logic [3:0] opr);
        return {opc, opr};
    endfunction

    task automatic cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic pushExp(input logic [4:0] opc, input logic [3:0] opr, input logic [9:0] pc);
        expT e;
        e.opc = opc;
        e.opr = opr;
        e.pc  = pc;
        expQ.push_back(e);
    endtask

    task automatic applyStimulus();
        bus.Start = 1'b1;
        cycle();
        bus.Start = 1'b0;
    endtask

    task automatic lutWrite(input logic [3:0] addr, input logic [9:0] data);
        bus.LutWe   = 1'b1;
        bus.LutAddr = addr;
        bus.LutData = data;
        cycle();
        bus.LutWe   = 1'b0;
    endtask

    task automatic clearRom();
        for (int i = 0; i < 1024; i++) rom[i] = '0;
    endtask

    initial begin
        Clk = 0; Reset = 1; errors = 0; checks = 0;
        takenSel = 0; forceBranch = 0;
        bus.Start = 0; bus.Stall = 0; bus.LutWe = 0; bus.LutAddr = '0; bus.LutData = '0;
        clearRom();
        cycle(); cycle();
        Reset = 0;
        checkOutput("reset_pc", 32'(bus.PC), 0);
        checkOutput("reset_valid", 32'(bus.InstValid), 0);
        checkOutput("reset_done", 32'(bus.Done), 0);
        checkOutput("reset_opcode", 32'(bus.Opcode), 0);

        // Sequential program ending in halt; the word behind the halt is discarded
        rom[0] = mk(ADD, 1); rom[1] = mk(SUB, 2); rom[2] = mk(XOR, 3);
        rom[3] = mk(HALT, 0); rom[4] = mk(ADD, 9);
        pushExp(ADD, 1, 1); pushExp(SUB, 2, 2); pushExp(XOR, 3, 3); pushExp(HALT, 0, 4);
        applyStimulus();
        checkOutput("start_pc", 32'(bus.PC), 0);
        checkOutput("start_valid", 32'(bus.InstValid), 0);
        repeat (4) cycle();
        checkOutput("pre_halt_done", 32'(bus.Done), 0);
        cycle();
        checkOutput("halt_done", 32'(bus.Done), 1);
        checkOutput("halt_valid", 32'(bus.InstValid), 0);
        checkOutput("halt_pc", 32'(bus.PC), 4);
        cycle(); cycle();
        checkOutput("done_pc_frozen", 32'(bus.PC), 4);
        checkOutput("done_held", 32'(bus.Done), 1);

        // Taken branch through table[3]=40, restart from DONE, Start in RUN ignored
        lutWrite(4'd3, 10'd40);
        rom[0] = mk(ADD, 1); rom[1] = mk(ADD, 2); rom[2] = mk(BEQ, 3);
        rom[3] = mk(SUB, 4); rom[4] = mk(HALT, 0);
        rom[40] = mk(XOR, 5); rom[41] = mk(HALT, 0);
        takenSel = 1;
        pushExp(ADD, 1, 1); pushExp(ADD, 2, 2); pushExp(BEQ, 3, 3);
        pushExp(XOR, 5, 41); pushExp(HALT, 0, 42);
        applyStimulus();
        checkOutput("restart_done", 32'(bus.Done), 0);
        checkOutput("restart_pc", 32'(bus.PC), 0);
        checkOutput("restart_valid", 32'(bus.InstValid), 0);
        bus.Start = 1'b1;
        cycle();
        bus.Start = 1'b0;
        checkOutput("run_start_ignored_pc", 32'(bus.PC), 1);
        checkOutput("run_start_ignored_valid", 32'(bus.InstValid), 1);
        cycle(); cycle();
        cycle();
        checkOutput("bubble_valid", 32'(bus.InstValid), 0);
        checkOutput("bubble_pc", 32'(bus.PC), 40);
        checkOutput("bubble_opcode", 32'(bus.Opcode), 0);
        cycle(); cycle(); cycle();
        checkOutput("br_done", 32'(bus.Done), 1);
        checkOutput("br_pc", 32'(bus.PC), 42);

        // Not-taken branch: fall through to PC 3 with no bubble
        takenSel = 0;
        pushExp(ADD, 1, 1); pushExp(ADD, 2, 2); pushExp(BEQ, 3, 3);
        pushExp(SUB, 4, 4); pushExp(HALT, 0, 5);
        applyStimulus();
        repeat (3) cycle();
        cycle();
        checkOutput("nt_pc", 32'(bus.PC), 4);
        checkOutput("nt_valid", 32'(bus.InstValid), 1);
        checkOutput("nt_opcode", 32'(bus.Opcode), 32'(SUB));
        cycle(); cycle();
        checkOutput("nt_done", 32'(bus.Done), 1);
        checkOutput("nt_pc_frozen", 32'(bus.PC), 5);

        // Stall 3 cycles over a valid taken beq; table write on the redirect edge uses old target
        takenSel = 1;
        rom[100] = mk(HALT, 0);
        pushExp(ADD, 1, 1); pushExp(ADD, 2, 2); pushExp(BEQ, 3, 3);
        pushExp(XOR, 5, 41); pushExp(HALT, 0, 42);
        applyStimulus();
        repeat (3) cycle();
        bus.Stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            checkOutput("stall_pc", 32'(bus.PC), 3);
            checkOutput("stall_opcode", 32'(bus.Opcode), 32'(BEQ));
            checkOutput("stall_valid", 32'(bus.InstValid), 1);
        end
        bus.Stall   = 1'b0;
        bus.LutWe   = 1'b1;
        bus.LutAddr = 4'd3;
        bus.LutData = 10'd100;
        cycle();
        bus.LutWe = 1'b0;
        checkOutput("same_edge_pc", 32'(bus.PC), 40);
        checkOutput("same_edge_valid", 32'(bus.InstValid), 0);
        cycle(); cycle(); cycle();
        checkOutput("stall_done", 32'(bus.Done), 1);

        // The new table entry now steers the branch to 100
        pushExp(ADD, 1, 1); pushExp(ADD, 2, 2); pushExp(BEQ, 3, 3); pushExp(HALT, 0, 101);
        applyStimulus();
        repeat (4) cycle();
        checkOutput("new_target_pc", 32'(bus.PC), 100);
        cycle(); cycle();
        checkOutput("new_target_done", 32'(bus.Done), 1);
        checkOutput("new_target_pc_frozen", 32'(bus.PC), 101);

        // Reset mid-run after 5 fetches
        clearRom();
        takenSel = 0;
        for (int i = 0; i < 10; i++) rom[i] = mk(ADD, 4'(i));
        pushExp(ADD, 0, 1); pushExp(ADD, 1, 2); pushExp(ADD, 2, 3); pushExp(ADD, 3, 4);
        applyStimulus();
        repeat (5) cycle();
        Reset = 1;
        cycle();
        Reset = 0;
        checkOutput("rst_pc", 32'(bus.PC), 0);
        checkOutput("rst_valid", 32'(bus.InstValid), 0);
        checkOutput("rst_done", 32'(bus.Done), 0);
        checkOutput("rst_opcode", 32'(bus.Opcode), 0);
        cycle();
        checkOutput("idle_pc", 32'(bus.PC), 0);
        checkOutput("idle_valid", 32'(bus.InstValid), 0);

        // Table cleared by reset: redirect via entry 3 lands at 0; then halt beats a forced branch
        rom[0] = mk(BEQ, 3);
        takenSel = 1;
        pushExp(BEQ, 3, 1); pushExp(HALT, 0, 1);
        applyStimulus();
        cycle(); cycle();
        checkOutput("tbl_zero_pc", 32'(bus.PC), 0);
        checkOutput("tbl_zero_valid", 32'(bus.InstValid), 0);
        rom[0] = mk(HALT, 0);
        forceBranch = 1;
        cycle(); cycle();
        checkOutput("halt_wins_done", 32'(bus.Done), 1);
        checkOutput("halt_wins_pc", 32'(bus.PC), 1);
        forceBranch = 0;
        takenSel = 0;

        // PC wraps 1023 -> 0 with the instruction stream continuous
        for (int i = 0; i < 1024; i++) rom[i] = mk(ADD, 4'(i));
        for (int i = 0; i < 1029; i++) pushExp(ADD, 4'(i % 16), 10'((i + 1) % 1024));
        applyStimulus();
        for (int k = 1; k <= 1030; k++) begin
            cycle();
            if (k == 1024) begin
                checkOutput("wrap_pc", 32'(bus.PC), 0);
                checkOutput("wrap_valid", 32'(bus.InstValid), 1);
            end
        end
        Reset = 1;
        cycle();
        Reset = 0;
        cycle();

        checkOutput("queue_drained", 32'(expQ.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
